// File: rtl/ice40_spram_bank_if.sv
// rtl/ice40_spram_bank_if.sv - request/response bus for ice40_spram_bank
interface ice40_spram_bank_if #(
    parameter int DATA_W = 16,
    parameter int BANKS  = 1
);
    localparam int ADDR_W = 14 + $clog2(BANKS);

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/4-1:0] req_wmask;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ice40_spram_bank.sv
// rtl/ice40_spram_bank.sv - 16/32-bit SPRAM bank with 2-cycle read pipeline; optional SPRAM_SLEEP_EN idle sleep
module ice40_spram_bank #(
    parameter int DATA_W      = 16,
    parameter int BANKS       = 1,
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 3
) (
    input  logic                clock,
    input  logic                reset,
    ice40_spram_bank_if.slave   bus
);
    localparam int LANES  = DATA_W / 16;
    localparam int ADDR_W = 14 + $clog2(BANKS);

    logic                accept;
    logic                active;
    logic                spram_sleep;
    logic [1:0]          req_bank;
    logic                ready_q;

    // Request register stage: these registers drive the SPRAM address/data/mask pins.
    logic                s0_v_q;
    logic                s0_we_q;
    logic [1:0]          s0_bank_q;
    logic [13:0]         s0_addr_q;
    logic [DATA_W-1:0]   s0_wdata_q;
    logic [DATA_W/4-1:0] s0_wmask_q;

    logic                s1_rd_q;
    logic [1:0]          s1_bank_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   rd_mux;

    // DATAOUT of every possible primitive position; absent ones read as zero.
    logic [15:0]         dout [4][2];

    if (BANKS > 1) begin : g_bsel
        assign req_bank = 2'(bus.req_addr[ADDR_W-1:14]);
    end else begin : g_bsel_one
        assign req_bank = 2'd0;
    end

    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.req_ready = ready_q & active;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Ready comes up on the first edge after reset is released.
    always_ff @(posedge clock) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    // Capture accepted requests; only the valid bit needs a reset value.
    always_ff @(posedge clock) begin
        if (reset) s0_v_q <= 1'b0;
        else       s0_v_q <= accept;
        if (accept) begin
            s0_we_q    <= bus.req_we;
            s0_bank_q  <= req_bank;
            s0_addr_q  <= bus.req_addr[13:0];
            s0_wdata_q <= bus.req_wdata;
            s0_wmask_q <= bus.req_wmask;
        end
    end

    // SB_SPRAM256KA-equivalent primitives (STANDBY=0, POWEROFF=1); CHIPSELECT only on the addressed bank.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        for (genvar l = 0; l < 2; l++) begin : g_lane
            if (b < BANKS && l < LANES) begin : g_prim
                logic [15:0] mem [0:16383];
                logic [15:0] dout_q;
                logic        cs;

                assign cs = s0_v_q && (s0_bank_q == 2'(b));

                // One access per cycle; MASKWREN works per nibble, DATAOUT holds between reads.
                always_ff @(posedge clock) begin
                    if (cs && !spram_sleep) begin
                        if (s0_we_q) begin
                            for (int n = 0; n < 4; n++) begin
                                if (s0_wmask_q[l*4+n]) mem[s0_addr_q][n*4+:4] <= s0_wdata_q[l*16+n*4+:4];
                            end
                        end else begin
                            dout_q <= mem[s0_addr_q];
                        end
                    end
                end

                assign dout[b][l] = dout_q;
            end else begin : g_none
                assign dout[b][l] = 16'h0000;
            end
        end
    end

    // The registered bank index picks which DATAOUT group forms the word.
    always_comb begin
        rd_mux = '0;
        for (int l = 0; l < LANES; l++) rd_mux[l*16+:16] = dout[s1_bank_q][l];
    end

    // Read pipeline tail: reset drops any in-flight response; rsp_rdata holds between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_rd_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            s1_rd_q     <= s0_v_q & ~s0_we_q;
            rsp_valid_q <= s1_rd_q;
            if (s1_rd_q) rsp_rdata_q <= rd_mux;
        end
        s1_bank_q <= s0_bank_q;
    end

`ifdef SPRAM_SLEEP_EN
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_SLEEP  = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

    logic [1:0]        state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic              sleep_q, sleep_d;
    logic              busy;

    assign busy        = s0_v_q | s1_rd_q;
    assign active      = (state_q == ST_ACTIVE);
    assign spram_sleep = sleep_q;

    // Sleep after IDLE_CYCLES idle cycles, wake on a pending request, never move with an access in flight.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        sleep_d = sleep_q;
        case (state_q)
            ST_ACTIVE: begin
                if (accept) begin
                    idle_d = '0;
                end else if (idle_q >= IDLE_W'(IDLE_CYCLES - 1)) begin
                    if (!busy) begin
                        state_d = ST_SLEEP;
                        sleep_d = 1'b1;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_SLEEP: begin
                if (bus.req_valid && !busy) begin
                    state_d = ST_WAKE;
                    sleep_d = 1'b0;
                    wake_d  = '0;
                end
            end
            ST_WAKE: begin
                if (!busy) begin
                    if (wake_q >= WAKE_W'(WAKE_CYCLES - 1)) begin
                        state_d = ST_ACTIVE;
                        idle_d  = '0;
                    end else begin
                        wake_d = wake_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                sleep_d = 1'b0;
            end
        endcase
    end

    // Power-state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
            sleep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            sleep_q <= sleep_d;
        end
    end
`else
    assign active      = 1'b1;
    assign spram_sleep = 1'b0;
`endif
endmodule

// File: tb/tb_ice40_spram_bank.sv
// tb/tb_ice40_spram_bank.sv - randomized model-checked bench for ice40_spram_bank
module tb_ice40_spram_bank;
    localparam int IDLE_N = 8;
    localparam int WAKE_N = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m16 [int];
    logic [31:0] m32 [int];
    logic [31:0] exp32 [$];

    ice40_spram_bank_if #(.DATA_W(16), .BANKS(1)) bus16 ();
    ice40_spram_bank_if #(.DATA_W(32), .BANKS(2)) bus32 ();

    ice40_spram_bank #(.DATA_W(16), .BANKS(1), .IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N)) u_dut16 (
        .clock(clock), .reset(reset), .bus(bus16)
    );
    ice40_spram_bank #(.DATA_W(32), .BANKS(2)) u_dut32 (
        .clock(clock), .reset(reset), .bus(bus32)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [7:0] mask);
        logic [31:0] r = old_w;
        for (int i = 0; i < 8; i++) if (mask[i]) r[i*4+:4] = new_w[i*4+:4];
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send16(input logic we, input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        int n = 0;
        bus16.req_valid = 1'b1; bus16.req_we = we; bus16.req_addr = a;
        bus16.req_wdata = d;    bus16.req_wmask = m;
        while (bus16.req_ready !== 1'b1 && n < 40) begin tick(); n++; end
        if (n == 40) begin
            vectors++; miscompares++;
            $display("FAIL send16_ready: req_ready never rose within %0d cycles", n);
        end
        tick();
        bus16.req_valid = 1'b0;
        if (we) m16[a] = merge({16'h0, m16.exists(a) ? m16[a] : 16'h0}, {16'h0, d}, {4'h0, m}) & 32'hFFFF;
    endtask

    task automatic send32(input logic we, input logic [14:0] a, input logic [31:0] d, input logic [7:0] m);
        int n = 0;
        bus32.req_valid = 1'b1; bus32.req_we = we; bus32.req_addr = a;
        bus32.req_wdata = d;    bus32.req_wmask = m;
        while (bus32.req_ready !== 1'b1 && n < 200) begin tick(); n++; end
        if (n == 200) begin
            vectors++; miscompares++;
            $display("FAIL send32_ready: req_ready never rose within %0d cycles", n);
        end
        tick();
        bus32.req_valid = 1'b0;
        if (we) m32[a] = merge(m32.exists(a) ? m32[a] : 32'h0, d, m);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vectors++; if (bus16.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready16: got %b want 0", bus16.req_ready); end
        vectors++; if (bus16.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rspv16: got %b want 0", bus16.rsp_valid); end
        vectors++; if (bus16.rsp_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rdata16: got %h want 0", bus16.rsp_rdata); end
        vectors++; if (bus32.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready32: got %b want 0", bus32.req_ready); end
        vectors++; if (bus32.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rspv32: got %b want 0", bus32.rsp_valid); end
        vectors++; if (bus32.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata32: got %h want 0", bus32.rsp_rdata); end
        reset = 1'b0;
        tick();
        vectors++; if (bus16.req_ready !== 1'b1) begin miscompares++; $display("FAIL rel_ready16: got %b want 1", bus16.req_ready); end
        vectors++; if (bus32.req_ready !== 1'b1) begin miscompares++; $display("FAIL rel_ready32: got %b want 1", bus32.req_ready); end
    endtask

    task automatic test_write_read16();
        logic [15:0] e;
        send16(1'b1, 14'h0123, 16'hBEEF, 4'hF);
        send16(1'b0, 14'h0123, 16'h0, 4'h0);
        e = m16[14'h0123];
        vectors++; if (bus16.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lat_e0: rsp_valid got %b want 0", bus16.rsp_valid); end
        tick();
        vectors++; if (bus16.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lat_e1: rsp_valid got %b want 0", bus16.rsp_valid); end
        tick();
        vectors++; if (bus16.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lat_e2: rsp_valid got %b want 1", bus16.rsp_valid); end
        vectors++; if (bus16.rsp_rdata !== e) begin miscompares++; $display("FAIL full_wr: rdata got %h want %h", bus16.rsp_rdata, e); end
        tick();
        vectors++; if (bus16.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL pulse: rsp_valid got %b want 0", bus16.rsp_valid); end
        vectors++; if (bus16.rsp_rdata !== e) begin miscompares++; $display("FAIL hold: rdata got %h want %h", bus16.rsp_rdata, e); end
        send16(1'b1, 14'h0123, 16'h1234, 4'h5);
        send16(1'b1, 14'h0123, 16'hFFFF, 4'h0);
        send16(1'b0, 14'h0123, 16'h0, 4'h0);
        e = m16[14'h0123];
        tick(); tick();
        vectors++; if (bus16.rsp_valid !== 1'b1 || bus16.rsp_rdata !== e) begin
            miscompares++; $display("FAIL mask_wr: valid %b rdata %h want 1 %h", bus16.rsp_valid, bus16.rsp_rdata, e);
        end
    endtask

    task automatic test_banks32();
        logic [31:0] ea, eb;
        send32(1'b1, 15'h4000, 32'hA5A5A5A5, 8'hFF);
        send32(1'b1, 15'h0000, 32'h5A5A5A5A, 8'hFF);
        send32(1'b0, 15'h4000, 32'h0, 8'h0);
        send32(1'b0, 15'h0000, 32'h0, 8'h0);
        ea = m32[15'h4000]; eb = m32[15'h0000];
        tick();
        vectors++; if (bus32.rsp_valid !== 1'b1 || bus32.rsp_rdata !== ea) begin
            miscompares++; $display("FAIL bank1: valid %b rdata %h want 1 %h", bus32.rsp_valid, bus32.rsp_rdata, ea);
        end
        tick();
        vectors++; if (bus32.rsp_valid !== 1'b1 || bus32.rsp_rdata !== eb) begin
            miscompares++; $display("FAIL bank0: valid %b rdata %h want 1 %h", bus32.rsp_valid, bus32.rsp_rdata, eb);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, cnt = 0;
        for (int i = 0; i < 8; i++) send16(1'b1, 14'(i), 16'($urandom), 4'hF);
        for (int i = 0; i < 8; i++) send16(1'b1, 14'(i), 16'($urandom), 4'($urandom_range(0, 15)));
        for (int c = 0; c < 14; c++) begin
            if (bus16.rsp_valid === 1'b1) begin
                if (first < 0) first = c;
                vectors++;
                if (bus16.rsp_rdata !== m16[cnt]) begin
                    miscompares++; $display("FAIL b2b_data%0d: got %h want %h", cnt, bus16.rsp_rdata, m16[cnt]);
                end
                cnt++;
            end
            if (c < 8) begin
                vectors++;
                if (bus16.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", c, bus16.req_ready); end
                bus16.req_valid = 1'b1; bus16.req_we = 1'b0; bus16.req_addr = 14'(c);
            end else begin
                bus16.req_valid = 1'b0;
            end
            tick();
        end
        vectors++; if (cnt != 8) begin miscompares++; $display("FAIL b2b_count: got %0d want 8", cnt); end
        vectors++; if (first != 3) begin miscompares++; $display("FAIL b2b_first: got %0d want 3", first); end
    endtask

    task automatic test_random32();
        logic [14:0] pool [10];
        logic [14:0] a;
        logic [31:0] d, e;
        logic [7:0]  m;
        logic        we;
        for (int i = 0; i < 8; i++) pool[i] = 15'(((i % 2) << 14) | (i * 37));
        pool[8] = 15'h3FFF; pool[9] = 15'h7FFF;
        for (int i = 0; i < 10; i++) send32(1'b1, pool[i], $urandom, 8'hFF);
        for (int c = 0; c < 80; c++) begin
            if (bus32.rsp_valid === 1'b1) begin
                vectors++;
                if (exp32.size() == 0) begin
                    miscompares++; $display("FAIL rnd32_extra: unexpected response %h", bus32.rsp_rdata);
                end else begin
                    e = exp32.pop_front();
                    if (bus32.rsp_rdata !== e) begin miscompares++; $display("FAIL rnd32_data: got %h want %h", bus32.rsp_rdata, e); end
                end
            end
            if (c < 70 && $urandom_range(0, 3) != 0) begin
                a = pool[$urandom_range(0, 9)]; d = $urandom; m = 8'($urandom); we = 1'($urandom);
                bus32.req_valid = 1'b1; bus32.req_we = we; bus32.req_addr = a;
                bus32.req_wdata = d;    bus32.req_wmask = m;
                if (bus32.req_ready === 1'b1) begin
                    if (we) m32[a] = merge(m32[a], d, m);
                    else    exp32.push_back(m32[a]);
                end
            end else begin
                bus32.req_valid = 1'b0;
            end
            tick();
        end
        bus32.req_valid = 1'b0;
        vectors++; if (exp32.size() != 0) begin miscompares++; $display("FAIL rnd32_drain: %0d responses missing", exp32.size()); end
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        send16(1'b0, 14'h0123, 16'h0, 4'h0);
        reset = 1'b1;
        tick(); if (bus16.rsp_valid === 1'b1) pulses++;
        tick(); if (bus16.rsp_valid === 1'b1) pulses++;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus16.rsp_valid === 1'b1) pulses++; end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rst_drop: %0d pulses want 0", pulses); end
        vectors++; if (bus16.rsp_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus16.rsp_rdata); end
    endtask

`ifdef SPRAM_SLEEP_EN
    task automatic test_sleep();
        int n = 0;
        logic [15:0] e;
        send16(1'b1, 14'h0200, 16'($urandom), 4'hF);
        e = m16[14'h0200];
        repeat (IDLE_N - 1) tick();
        vectors++; if (u_dut16.sleep_q !== 1'b0) begin miscompares++; $display("FAIL sleep_early: got %b want 0", u_dut16.sleep_q); end
        tick();
        vectors++; if (u_dut16.sleep_q !== 1'b1) begin miscompares++; $display("FAIL sleep_enter: got %b want 1", u_dut16.sleep_q); end
        bus16.req_valid = 1'b1; bus16.req_we = 1'b0; bus16.req_addr = 14'h0200;
        vectors++; if (bus16.req_ready !== 1'b0) begin miscompares++; $display("FAIL sleep_ready: got %b want 0", bus16.req_ready); end
        tick();
        vectors++; if (u_dut16.sleep_q !== 1'b0) begin miscompares++; $display("FAIL sleep_exit: got %b want 0", u_dut16.sleep_q); end
        while (bus16.req_ready !== 1'b1 && n < 20) begin n++; tick(); end
        vectors++; if (n != WAKE_N) begin miscompares++; $display("FAIL wake_len: got %0d want %0d", n, WAKE_N); end
        tick();
        bus16.req_valid = 1'b0;
        tick(); tick();
        vectors++; if (bus16.rsp_valid !== 1'b1 || bus16.rsp_rdata !== e) begin
            miscompares++; $display("FAIL wake_read: valid %b rdata %h want 1 %h", bus16.rsp_valid, bus16.rsp_rdata, e);
        end
    endtask
`endif

    initial begin
        bus16.req_valid = 1'b0; bus16.req_we = 1'b0; bus16.req_addr = '0; bus16.req_wdata = '0; bus16.req_wmask = '0;
        bus32.req_valid = 1'b0; bus32.req_we = 1'b0; bus32.req_addr = '0; bus32.req_wdata = '0; bus32.req_wmask = '0;
        @(negedge clock);
        test_reset();
        test_write_read16();
        test_banks32();
        test_back_to_back();
        test_random32();
        test_reset_inflight();
`ifdef SPRAM_SLEEP_EN
        test_sleep();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
